// File: rtl/rvcpu_if.sv
// rtl/rvcpu_if.sv - word-wide memory bus between the RV32I core and its RAM
interface rvcpu_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output wstrb, input rdata);
    modport slave  (input addr, input wdata, input wstrb, output rdata);
endinterface

// File: rtl/rvcpu_top.sv
// rtl/rvcpu_top.sv - multi-cycle RV32I core (cpu0) plus unified synchronous word RAM
// Optional: RVCPU_ILLEGAL_HALT_EN makes unrecognised opcodes halt with x10 = all ones.
module rvcpu_core #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic       clk,
    input  logic       rst,
    rvcpu_if.master    bus,
    output logic       halted
);
`ifdef RVCPU_ILLEGAL_HALT_EN
    localparam bit ILLEGAL_HALT = 1'b1;
`else
    localparam bit ILLEGAL_HALT = 1'b0;
`endif

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    state_t state, state_nxt;

    logic [31:0] pc;
    logic [31:0] regs [0:31];

    logic [4:0]  rd_q;
    logic        wr_q, load_q, store_q, sys_halt_q, illegal_q;
    logic [2:0]  f3_q;
    logic [31:0] res_q, npc_q, addr_q, wdata_q;
    logic [3:0]  strb_q;

    // Decode works straight off the RAM read data while in EXEC.
    logic [31:0] ins, rs1v, rs2v, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] e_res, e_npc, e_addr, e_wdata;
    logic [3:0]  e_strb;
    logic        e_wr, e_load, e_store, e_sys, e_ill, e_take;
    logic [31:0] ld_val, ld_byte, ld_half;

    assign ins   = bus.rdata;
    assign op    = ins[6:0];
    assign f3    = ins[14:12];
    assign rs1v  = regs[ins[19:15]];
    assign rs2v  = regs[ins[24:20]];
    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] fn, input logic alt);
        case (fn)
            3'b000:  return alt ? a - b : a + b;
            3'b001:  return a << b[4:0];
            3'b010:  return {31'b0, $signed(a) < $signed(b)};
            3'b011:  return {31'b0, a < b};
            3'b100:  return a ^ b;
            3'b101:  return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    always_comb begin
        e_res   = 32'h0;
        e_npc   = pc + 32'd4;
        e_addr  = pc;
        e_wdata = rs2v;
        e_strb  = 4'b1111;
        e_wr    = 1'b0;
        e_load  = 1'b0;
        e_store = 1'b0;
        e_sys   = 1'b0;
        e_ill   = 1'b0;
        e_take  = 1'b0;
        case (op)
            7'b0110111: begin e_res = imm_u;      e_wr = 1'b1; end
            7'b0010111: begin e_res = pc + imm_u; e_wr = 1'b1; end
            7'b1101111: begin e_res = pc + 32'd4; e_wr = 1'b1; e_npc = pc + imm_j; end
            7'b1100111: begin
                e_res = pc + 32'd4;
                e_wr  = 1'b1;
                e_npc = (rs1v + imm_i) & ~32'd1;
            end
            7'b1100011: begin
                case (f3)
                    3'b000:  e_take = (rs1v == rs2v);
                    3'b001:  e_take = (rs1v != rs2v);
                    3'b100:  e_take = ($signed(rs1v) <  $signed(rs2v));
                    3'b101:  e_take = ($signed(rs1v) >= $signed(rs2v));
                    3'b110:  e_take = (rs1v <  rs2v);
                    3'b111:  e_take = (rs1v >= rs2v);
                    default: e_take = 1'b0;
                endcase
                if (e_take) e_npc = pc + imm_b;
            end
            7'b0000011: begin e_load = 1'b1; e_wr = 1'b1; e_addr = rs1v + imm_i; end
            7'b0100011: begin
                e_store = 1'b1;
                e_addr  = rs1v + imm_s;
                case (f3)
                    3'b000: begin
                        e_wdata = {4{rs2v[7:0]}};
                        e_strb  = 4'b0001 << e_addr[1:0];
                    end
                    3'b001: begin
                        e_wdata = {2{rs2v[15:0]}};
                        e_strb  = e_addr[1] ? 4'b1100 : 4'b0011;
                    end
                    default: ;
                endcase
            end
            7'b0010011: begin e_res = alu(rs1v, imm_i, f3, (f3 == 3'b101) && ins[30]); e_wr = 1'b1; end
            7'b0110011: begin e_res = alu(rs1v, rs2v, f3, ins[30]); e_wr = 1'b1; end
            7'b0001111: ;
            7'b1110011: e_sys = (f3 == 3'b000);
            default:    e_ill = 1'b1;
        endcase
    end

    assign ld_byte = bus.rdata >> {addr_q[1:0], 3'b000};
    assign ld_half = addr_q[1] ? {16'b0, bus.rdata[31:16]} : {16'b0, bus.rdata[15:0]};

    always_comb begin
        case (f3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte[7:0]};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half[15:0]};
            3'b100:  ld_val = {24'b0, ld_byte[7:0]};
            3'b101:  ld_val = ld_half;
            default: ld_val = bus.rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC:  state_nxt = (e_load || e_store) ? S_MEM : S_WB;
            S_MEM:   state_nxt = S_WB;
            S_WB:    state_nxt = (sys_halt_q || (ILLEGAL_HALT && illegal_q)) ? S_HALT : S_FETCH;
            default: state_nxt = S_HALT;
        endcase
    end

    always_comb begin
        bus.addr  = pc;
        bus.wdata = wdata_q;
        bus.wstrb = 4'b0000;
        case (state)
            S_EXEC: bus.addr = e_addr;
            S_MEM: begin
                bus.addr = addr_q;
                if (store_q) bus.wstrb = strb_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            halted     <= 1'b0;
            rd_q       <= 5'd0;
            wr_q       <= 1'b0;
            load_q     <= 1'b0;
            store_q    <= 1'b0;
            sys_halt_q <= 1'b0;
            illegal_q  <= 1'b0;
            f3_q       <= 3'd0;
            res_q      <= 32'h0;
            npc_q      <= 32'h0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            strb_q     <= 4'h0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else begin
            case (state)
                S_EXEC: begin
                    rd_q       <= ins[11:7];
                    wr_q       <= e_wr;
                    load_q     <= e_load;
                    store_q    <= e_store;
                    sys_halt_q <= e_sys;
                    illegal_q  <= e_ill;
                    f3_q       <= f3;
                    res_q      <= e_res;
                    npc_q      <= e_npc;
                    addr_q     <= e_addr;
                    wdata_q    <= e_wdata;
                    strb_q     <= e_strb;
                end
                S_MEM: if (load_q) res_q <= ld_val;
                S_WB: begin
                    // A halting instruction leaves pc pointing at itself.
                    if (sys_halt_q || (ILLEGAL_HALT && illegal_q)) halted <= 1'b1;
                    else                                           pc     <= npc_q;
                    if (wr_q && rd_q != 5'd0) regs[rd_q] <= res_q;
                    if (ILLEGAL_HALT && illegal_q) regs[10] <= 32'hFFFF_FFFF;
                end
                default: ;
            endcase
        end
    end
endmodule

module rvcpu_top #(
    parameter int          MEM_WORDS     = 4096,
    parameter              MEM_INIT_FILE = "program.hex",
    parameter logic [31:0] RESET_PC      = 32'h0
) (
    input  logic clk,
    input  logic rst,
    output logic halted
);
    localparam int AW = $clog2(MEM_WORDS);

    rvcpu_if bus ();

    rvcpu_core #(.RESET_PC(RESET_PC)) cpu0 (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.master),
        .halted (halted)
    );

    logic [31:0]   mem [0:MEM_WORDS-1];
    logic [AW-1:0] idx;
    logic          unused_bits;

    assign idx         = bus.addr[2 +: AW];
    assign unused_bits = ^{bus.addr[31:2+AW], bus.addr[1:0], MEM_INIT_FILE};

    // Contents survive reset; image is placed by whoever owns the hierarchy.
    always_ff @(posedge clk) begin
        bus.rdata <= mem[idx];
        for (int b = 0; b < 4; b++)
            if (bus.wstrb[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
    end
endmodule

// File: tb/tb_rvcpu_top.sv
// tb/tb_rvcpu_top.sv - directed and random RV32I programs checked against an instruction-level model
module tb_rvcpu_top;
    localparam int MW = 4096;
`ifdef RVCPU_ILLEGAL_HALT_EN
    localparam bit ILL_HALT = 1'b1;
`else
    localparam bit ILL_HALT = 1'b0;
`endif
    localparam logic [31:0] ECALL = 32'h0000_0073;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halted;

    rvcpu_top #(.MEM_WORDS(MW), .MEM_INIT_FILE("program.hex"), .RESET_PC(32'h0)) dut (
        .clk    (clk),
        .rst    (rst),
        .halted (halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] img    [0:MW-1];
    logic [31:0] m_mem  [0:MW-1];
    logic [31:0] m_regs [0:31];
    logic [31:0] m_pc;
    int          m_cycles;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] fn, input bit alt);
        int unsigned sh;
        sh = b % 32;
        case (fn)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Instruction-at-a-time interpreter; also tallies cycles at 3 per instruction, 4 per memory op.
    task automatic model_run();
        logic [31:0] ins, a, b, nxt, ea, w, v, ii, is, ib, iu, ij;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        int          wi, steps;
        bit          done;
        for (int i = 0; i < MW; i++) m_mem[i] = img[i];
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_pc = 32'h0; m_cycles = 0; done = 1'b0; steps = 0;
        while (!done && steps < 20000) begin
            steps++;
            ins = m_mem[int'((m_pc / 4) % MW)];
            op = ins[6:0]; f3 = ins[14:12]; rd = ins[11:7];
            a = m_regs[ins[19:15]]; b = m_regs[ins[24:20]];
            ii = {{20{ins[31]}}, ins[31:20]};
            is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            iu = {ins[31:12], 12'b0};
            ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            nxt = m_pc + 4;
            m_cycles += 3;
            case (op)
                7'h37: m_regs[rd] = iu;
                7'h17: m_regs[rd] = m_pc + iu;
                7'h6F: begin m_regs[rd] = m_pc + 4; nxt = m_pc + ij; end
                7'h67: begin nxt = (a + ii) & 32'hFFFF_FFFE; m_regs[rd] = m_pc + 4; end
                7'h63: begin
                    if ((f3 == 0 && a == b) || (f3 == 1 && a != b) ||
                        (f3 == 4 && $signed(a) < $signed(b)) || (f3 == 5 && $signed(a) >= $signed(b)) ||
                        (f3 == 6 && a < b) || (f3 == 7 && a >= b))
                        nxt = m_pc + ib;
                end
                7'h03: begin
                    m_cycles++;
                    ea = a + ii; wi = int'((ea / 4) % MW); w = m_mem[wi];
                    case (f3)
                        3'd0, 3'd4: begin
                            v = (w >> (8 * (ea % 4))) & 32'hFF;
                            if (f3 == 0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
                        end
                        3'd1, 3'd5: begin
                            v = (w >> (16 * ((ea / 2) % 2))) & 32'hFFFF;
                            if (f3 == 1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
                        end
                        default: v = w;
                    endcase
                    m_regs[rd] = v;
                end
                7'h23: begin
                    m_cycles++;
                    ea = a + is; wi = int'((ea / 4) % MW);
                    case (f3)
                        3'd0:    m_mem[wi][8 * (ea % 4) +: 8] = b[7:0];
                        3'd1:    m_mem[wi][16 * ((ea / 2) % 2) +: 16] = b[15:0];
                        default: m_mem[wi] = b;
                    endcase
                end
                7'h13: m_regs[rd] = ref_alu(a, ii, f3, f3 == 5 && ins[30]);
                7'h33: m_regs[rd] = ref_alu(a, b, f3, ins[30]);
                7'h0F: ;
                7'h73: if (f3 == 0) done = 1'b1;
                default: if (ILL_HALT) begin m_regs[10] = 32'hFFFF_FFFF; done = 1'b1; end
            endcase
            m_regs[0] = 32'h0;
            if (!done) m_pc = nxt;
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < MW; i++) img[i] = 32'h0;
    endtask

    task automatic start_dut();
        rst = 1'b1;
        for (int i = 0; i < MW; i++) dut.mem[i] = img[i];
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_halt(input int limit, output int cyc);
        cyc = 0;
        while (halted !== 1'b1 && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic compare_all(input string name, input int cyc);
        check({name, "_halted"}, {31'b0, halted}, 32'd1);
        check({name, "_cycles"}, cyc, m_cycles);
        check({name, "_pc"}, dut.cpu0.pc, m_pc);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s_x%0d", name, i), dut.cpu0.regs[i], m_regs[i]);
        for (int i = 256; i < 320; i++)
            check($sformatf("%s_mem%0d", name, i), dut.mem[i], m_mem[i]);
    endtask

    initial begin
        int cyc;
        int kind;
        int n;
        logic [2:0] bf3 [0:5];
        logic [2:0] lf3 [0:4];
        logic [2:0] f3;
        logic [4:0] rd, rs1, rs2;
        logic [11:0] imm;
        bf3[0] = 3'd0; bf3[1] = 3'd1; bf3[2] = 3'd4; bf3[3] = 3'd5; bf3[4] = 3'd6; bf3[5] = 3'd7;
        lf3[0] = 3'd0; lf3[1] = 3'd1; lf3[2] = 3'd2; lf3[3] = 3'd4; lf3[4] = 3'd5;

        // 1: minimal pass image, reset state, latency, frozen after halt
        clear_img();
        img[0] = enc_i(12'h000, 5'd0, 3'd0, 5'd10, 7'h13);
        img[1] = ECALL;
        model_run();
        rst = 1'b1;
        for (int i = 0; i < MW; i++) dut.mem[i] = img[i];
        @(negedge clk);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_pc", dut.cpu0.pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_halt(200, cyc);
        compare_all("t1", cyc);
        check("t1_by_cycle8", (cyc <= 8) ? 32'd1 : 32'd0, 32'd1);
        check("t1_x10", dut.cpu0.regs[10], 32'h0);
        repeat (5) @(posedge clk);
        #1;
        check("t1_pc_frozen", dut.cpu0.pc, 32'd4);
        check("t1_halt_sticky", {31'b0, halted}, 32'd1);

        // 2: shifts and unsigned compare
        clear_img();
        img[0] = enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13);
        img[1] = enc_i(12'd28, 5'd1, 3'd5, 5'd2, 7'h13);
        img[2] = enc_i(12'h41C, 5'd1, 3'd5, 5'd3, 7'h13);
        img[3] = enc_r(7'h00, 5'd1, 5'd0, 3'd3, 5'd4);
        img[4] = ECALL;
        model_run(); start_dut(); wait_halt(200, cyc);
        compare_all("t2", cyc);
        check("t2_srli", dut.cpu0.regs[2], 32'h0000_000F);
        check("t2_srai", dut.cpu0.regs[3], 32'hFFFF_FFFF);
        check("t2_sltu", dut.cpu0.regs[4], 32'd1);

        // 3: store word then sub-word loads
        clear_img();
        img[0] = enc_u(20'h12345, 5'd5, 7'h37);
        img[1] = enc_i(12'h678, 5'd5, 3'd0, 5'd5, 7'h13);
        img[2] = enc_s(12'h100, 5'd5, 5'd0, 3'd2);
        img[3] = enc_i(12'h103, 5'd0, 3'd0, 5'd6, 7'h03);
        img[4] = enc_i(12'h102, 5'd0, 3'd5, 5'd7, 7'h03);
        img[5] = ECALL;
        model_run(); start_dut(); wait_halt(200, cyc);
        compare_all("t3", cyc);
        check("t3_lb", dut.cpu0.regs[6], 32'h0000_0012);
        check("t3_lhu", dut.cpu0.regs[7], 32'h0000_1234);
        check("t3_sw", dut.mem[64], 32'h1234_5678);

        // 4: taken branch, JAL link, x0 write discarded
        clear_img();
        img[0] = enc_i(12'd1, 5'd0, 3'd0, 5'd2, 7'h13);
        img[1] = enc_b(13'd8, 5'd0, 5'd2, 3'd1);
        img[2] = enc_i(12'd1, 5'd0, 3'd0, 5'd10, 7'h13);
        img[3] = enc_j(21'd8, 5'd1);
        img[4] = enc_i(12'd2, 5'd0, 3'd0, 5'd10, 7'h13);
        img[5] = enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13);
        img[6] = ECALL;
        model_run(); start_dut(); wait_halt(200, cyc);
        compare_all("t4", cyc);
        check("t4_x10", dut.cpu0.regs[10], 32'h0);
        check("t4_link", dut.cpu0.regs[1], 32'd16);
        check("t4_x0", dut.cpu0.regs[0], 32'h0);

        // 5: reset in the middle of a counting loop
        clear_img();
        img[0] = enc_i(12'd0, 5'd0, 3'd0, 5'd1, 7'h13);
        img[1] = enc_i(12'd20, 5'd0, 3'd0, 5'd2, 7'h13);
        img[2] = enc_i(12'd1, 5'd1, 3'd0, 5'd1, 7'h13);
        img[3] = enc_b(13'h1FFC, 5'd2, 5'd1, 3'd1);
        img[4] = enc_i(12'd0, 5'd0, 3'd0, 5'd10, 7'h13);
        img[5] = ECALL;
        model_run(); start_dut();
        repeat (40) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_halted", {31'b0, halted}, 32'd0);
        check("t5_rst_pc", dut.cpu0.pc, 32'h0);
        check("t5_rst_x1", dut.cpu0.regs[1], 32'h0);
        check("t5_rst_x2", dut.cpu0.regs[2], 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_halt(1000, cyc);
        compare_all("t5", cyc);
        check("t5_count", dut.cpu0.regs[1], 32'd20);

        // 6: all-zero word at reset vector
        clear_img();
        img[1] = ECALL;
        model_run(); start_dut(); wait_halt(200, cyc);
        compare_all("t6", cyc);
        check("t6_pc", dut.cpu0.pc, ILL_HALT ? 32'd0 : 32'd4);
        check("t6_x10", dut.cpu0.regs[10], ILL_HALT ? 32'hFFFF_FFFF : 32'h0);

        // Random programs of ALU, memory and forward control-flow instructions
        for (int t = 0; t < 8; t++) begin
            clear_img();
            for (int i = 256; i < 320; i++) img[i] = $urandom;
            n = 30;
            for (int j = 0; j < n; j++) begin
                kind = $urandom_range(0, 9);
                rd  = 5'($urandom_range(0, 15));
                rs1 = 5'($urandom_range(0, 15));
                rs2 = 5'($urandom_range(0, 15));
                f3  = 3'($urandom_range(0, 7));
                imm = 12'($urandom);
                case (kind)
                    0, 1, 2: begin
                        if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
                        if (f3 == 3'd5) imm = {1'b0, imm[10], 5'h00, imm[4:0]};
                        img[j] = enc_i(imm, rs1, f3, rd, 7'h13);
                    end
                    3, 4: img[j] = enc_r(((f3 == 3'd0 || f3 == 3'd5) && imm[0]) ? 7'h20 : 7'h00,
                                         rs2, rs1, f3, rd);
                    5: img[j] = enc_u(20'($urandom), rd, imm[0] ? 7'h37 : 7'h17);
                    6: img[j] = enc_s(12'h400 + 12'($urandom_range(0, 255)), rs2, 5'd0,
                                      3'($urandom_range(0, 2)));
                    7: img[j] = enc_i(12'h400 + 12'($urandom_range(0, 255)), 5'd0,
                                      lf3[$urandom_range(0, 4)], rd, 7'h03);
                    8: img[j] = enc_b(13'd8, rs2, rs1, bf3[$urandom_range(0, 5)]);
                    default: img[j] = enc_j(21'd8, rd);
                endcase
            end
            img[n]     = ECALL;
            img[n + 1] = ECALL;
            model_run(); start_dut(); wait_halt(2000, cyc);
            compare_all($sformatf("rand%0d", t), cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
